uart_tx_fifo_ctrl: RTL and testbench



---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_sync_fifo.sv | 60 ++++++
 rtl/uart_tx_fifo_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_fifo_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic TXD_IDLE  = 1'b1;
  localparam logic START_BIT = 1'b0;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; overflow/underflow requests are ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointers are exactly AW bits wide so they wrap modulo DEPTH for free.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// UART transmitter with baud divider and transmit FIFO, all on clk.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          din,
  input  logic                          din_valid,
  output logic                          din_ready,
  input  logic                          parity_odd,
  output logic                          txd,
  output logic                          busy,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 bit_end;
  logic                 pop;
  logic                 fifo_full;
  logic [DATA_BITS-1:0] fifo_rdata;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (din_valid && din_ready),
    .wdata (din),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign din_ready = !fifo_full;
  assign bit_end   = (baud_q == BAUD_LAST);

`ifdef UART_TX_PARITY_EN
  localparam tx_state_e AFTER_DATA = ST_PARITY;
  logic par_q, par_d, par_load;
  assign par_load = (^fifo_rdata) ^ (parity_odd == PARITY_ODD);
`else
  localparam tx_state_e AFTER_DATA = ST_STOP;
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != ST_IDLE) baud_d = bit_end ? '0 : baud_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
`ifdef UART_TX_PARITY_EN
          par_d   = par_load;
`endif
          baud_d  = '0;
          idx_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = AFTER_DATA;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (idx_q != STOP_LAST) begin
            idx_d = idx_q + 1'b1;
          end else if (!fifo_empty) begin
            // Chain straight into the next frame with no idle gap.
            pop     = 1'b1;
            shift_d = fifo_rdata;
`ifdef UART_TX_PARITY_EN
            par_d   = par_load;
`endif
            idx_d   = '0;
            state_d = ST_START;
          end else begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level and busy follow the registered state one edge later.
  always_comb begin
    txd_d = TXD_IDLE;
    case (state_q)
      ST_START:  txd_d = START_BIT;
      ST_DATA:   txd_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = par_q;
`endif
      default:   txd_d = TXD_IDLE;
    endcase
    busy_d = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= TXD_IDLE;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign txd  = txd_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Self-checking bench for uart_tx_fifo_ctrl; follows UART_TX_PARITY_EN if defined.
module tb_uart_tx_fifo_ctrl;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int DIV1 = 4;
  localparam int F1   = DIV1 * (1 + 8 + P + 1);
  localparam int DIV2 = 3;
  localparam int F2   = DIV2 * (1 + 5 + P + 2);

  logic       clk;
  logic       reset;
  logic [7:0] din;
  logic       din_valid, din_ready, parity_odd, txd, busy, fifo_empty;
  logic [2:0] fifo_count;
  logic [4:0] d2_din;
  logic       d2_valid, d2_ready, d2_par, d2_txd, d2_busy, d2_empty;
  logic [1:0] d2_count;

  int n_checks = 0;
  int n_pass   = 0;
  logic exp_w[$];

  uart_tx_fifo_ctrl #(.DATA_BITS(8), .STOP_BITS(1), .CLK_DIV(DIV1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .parity_odd(parity_odd), .txd(txd), .busy(busy), .fifo_empty(fifo_empty),
    .fifo_count(fifo_count));

  uart_tx_fifo_ctrl #(.DATA_BITS(5), .STOP_BITS(2), .CLK_DIV(DIV2), .FIFO_DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .din(d2_din), .din_valid(d2_valid), .din_ready(d2_ready),
    .parity_odd(d2_par), .txd(d2_txd), .busy(d2_busy), .fifo_empty(d2_empty),
    .fifo_count(d2_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Appends the per-cycle line levels of one frame to exp_w.
  function automatic void model_frame(input logic [8:0] b, input logic po, input int db,
                                      input int sb, input int div);
    logic bits[$];
    logic p;
    p = po;
    bits.push_back(1'b0);
    for (int i = 0; i < db; i++) begin
      bits.push_back(b[i]);
      p = p ^ b[i];
    end
    if (P == 1) bits.push_back(p);
    for (int i = 0; i < sb; i++) bits.push_back(1'b1);
    foreach (bits[i]) for (int k = 0; k < div; k++) exp_w.push_back(bits[i]);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_checks++; if (txd !== 1'b1) $display("FAIL reset_txd got=%b exp=1", txd); else n_pass++;
    n_checks++; if (din_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", din_ready); else n_pass++;
    n_checks++; if (fifo_empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", fifo_empty); else n_pass++;
    n_checks++; if (fifo_count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", fifo_count); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (d2_txd !== 1'b1) $display("FAIL reset_d2_txd got=%b exp=1", d2_txd); else n_pass++;
    n_checks++; if (d2_ready !== 1'b1) $display("FAIL reset_d2_ready got=%b exp=1", d2_ready); else n_pass++;
  endtask

  task automatic test_single_frame();
    logic [7:0] b;
    logic po, eb;
    for (int f = 0; f < 5; f++) begin
      b  = (f == 0) ? 8'hA5 : 8'($urandom);
      po = (f == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      exp_w.delete();
      exp_w.push_back(1'b1);
      exp_w.push_back(1'b1);
      model_frame({1'b0, b}, po, 8, 1, DIV1);
      repeat (3) exp_w.push_back(1'b1);
      din = b; parity_odd = po; din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      for (int s = 0; s < exp_w.size(); s++) begin
        if (s >= 1) begin
          din = 8'($urandom);
          parity_odd = 1'($urandom_range(0, 1));
        end
        eb = (s >= 2) && (s < 2 + F1);
        n_checks++;
        if (txd !== exp_w[s]) $display("FAIL frame%0d_txd s=%0d got=%b exp=%b", f, s, txd, exp_w[s]);
        else n_pass++;
        n_checks++;
        if (busy !== eb) $display("FAIL frame%0d_busy s=%0d got=%b exp=%b", f, s, busy, eb);
        else n_pass++;
        tick();
      end
    end
  endtask

  task automatic test_parity();
    logic ep;
    for (int po = 0; po < 2; po++) begin
      ep = (P == 1) ? logic'(($countones(8'hA5) % 2) ^ po) : 1'b1;
      din = 8'hA5; parity_odd = 1'(po); din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      for (int s = 0; s < F1 + 4; s++) begin
        if (s == 2 + DIV1 * 9 + DIV1 / 2) begin
          n_checks++;
          if (txd !== ep) $display("FAIL parity_bit po=%0d got=%b exp=%b", po, txd, ep); else n_pass++;
        end
        if (s == 1 + F1) begin
          n_checks++;
          if (busy !== 1'b1) $display("FAIL parity_len_last po=%0d got=%b exp=1", po, busy); else n_pass++;
        end
        if (s == 2 + F1) begin
          n_checks++;
          if (busy !== 1'b0) $display("FAIL parity_len_end po=%0d got=%b exp=0", po, busy); else n_pass++;
        end
        tick();
      end
    end
  endtask

  task automatic test_fifo_fill();
    logic [7:0] bytes[5];
    logic po, eb, er, ee;
    int pushes, pops, ec, total;
    for (int i = 0; i < 5; i++) bytes[i] = 8'(i + 1);
    po = 1'($urandom_range(0, 1));
    exp_w.delete();
    exp_w.push_back(1'b1);
    exp_w.push_back(1'b1);
    for (int i = 0; i < 5; i++) model_frame({1'b0, bytes[i]}, po, 8, 1, DIV1);
    repeat (4) exp_w.push_back(1'b1);
    total = exp_w.size();
    parity_odd = po; din = bytes[0]; din_valid = 1'b1;
    tick();
    for (int s = 0; s < total; s++) begin
      if (s < 4) begin
        din = bytes[s + 1];
        din_valid = 1'b1;
      end else begin
        din_valid = 1'b0;
        din = 8'($urandom);
      end
      pushes = (s + 1 < 5) ? s + 1 : 5;
      pops = 0;
      for (int k = 0; k < 5; k++) if (s >= 1 + k * F1) pops++;
      ec = pushes - pops;
      er = (ec != 4);
      ee = (ec == 0);
      eb = (s >= 2) && (s < 2 + 5 * F1);
      n_checks++;
      if (txd !== exp_w[s]) $display("FAIL fill_txd s=%0d got=%b exp=%b", s, txd, exp_w[s]); else n_pass++;
      n_checks++;
      if (busy !== eb) $display("FAIL fill_busy s=%0d got=%b exp=%b", s, busy, eb); else n_pass++;
      n_checks++;
      if (fifo_count !== 3'(ec)) $display("FAIL fill_count s=%0d got=%0d exp=%0d", s, fifo_count, ec); else n_pass++;
      n_checks++;
      if (din_ready !== er) $display("FAIL fill_ready s=%0d got=%b exp=%b", s, din_ready, er); else n_pass++;
      n_checks++;
      if (fifo_empty !== ee) $display("FAIL fill_empty s=%0d got=%b exp=%b", s, fifo_empty, ee); else n_pass++;
      tick();
    end
  endtask

  task automatic test_stop2();
    logic [4:0] b2;
    logic po, eb;
    b2 = 5'($urandom);
    po = 1'($urandom_range(0, 1));
    exp_w.delete();
    exp_w.push_back(1'b1);
    exp_w.push_back(1'b1);
    model_frame({4'd0, 5'h1F}, po, 5, 2, DIV2);
    model_frame({4'd0, b2}, po, 5, 2, DIV2);
    repeat (3) exp_w.push_back(1'b1);
    d2_par = po; d2_din = 5'h1F; d2_valid = 1'b1;
    tick();
    d2_din = b2;
    for (int s = 0; s < exp_w.size(); s++) begin
      if (s >= 1) d2_valid = 1'b0;
      eb = (s >= 2) && (s < 2 + 2 * F2);
      n_checks++;
      if (d2_txd !== exp_w[s]) $display("FAIL stop2_txd s=%0d got=%b exp=%b", s, d2_txd, exp_w[s]); else n_pass++;
      n_checks++;
      if (d2_busy !== eb) $display("FAIL stop2_busy s=%0d got=%b exp=%b", s, d2_busy, eb); else n_pass++;
      tick();
    end
  endtask

  task automatic test_reset_mid_frame();
    din = 8'hA5; parity_odd = 1'b0; din_valid = 1'b1;
    tick();
    din = 8'h3C;
    tick();
    din_valid = 1'b0;
    // now at sample 1; DATA bit 3 spans samples 2+4*DIV1 .. 2+5*DIV1-1
    repeat (2 + 4 * DIV1) tick();
    n_checks++;
    if (txd !== 1'b0) $display("FAIL mid_pre_txd got=%b exp=0", txd); else n_pass++;
    n_checks++;
    if (fifo_count !== 3'd1) $display("FAIL mid_pre_count got=%0d exp=1", fifo_count); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (txd !== 1'b1) $display("FAIL mid_rst_txd got=%b exp=1", txd); else n_pass++;
    n_checks++;
    if (fifo_count !== 3'd0) $display("FAIL mid_rst_count got=%0d exp=0", fifo_count); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL mid_rst_busy got=%b exp=0", busy); else n_pass++;
    n_checks++;
    if (fifo_empty !== 1'b1) $display("FAIL mid_rst_empty got=%b exp=1", fifo_empty); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < 3 * F1; s++) begin
      tick();
      n_checks++;
      if (txd !== 1'b1 || busy !== 1'b0)
        $display("FAIL mid_after s=%0d got txd=%b busy=%b exp txd=1 busy=0", s, txd, busy);
      else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1;
    din = '0; din_valid = 1'b0; parity_odd = 1'b0;
    d2_din = '0; d2_valid = 1'b0; d2_par = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    tick();
    test_single_frame();
    test_parity();
    test_fifo_fill();
    test_stop2();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
